// File: rtl/trace_capture_fifo.sv
// Trace capture FIFO: queues core register writes and data-memory accesses for a trace consumer.
// Optional macro TRACE_MEM_EN enables memory-event capture; without it only register writes are queued.
module trace_capture_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [1:0]               out_kind,
    output logic [8:0]               out_idx,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]        r_kind [DEPTH];
    logic [8:0]        r_idx  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_ovf;

    logic              w_reg_ev, w_mem_ev;
    logic [1:0]        w_mem_kind;
    logic [DATA_W-1:0] w_mem_data;
    logic [8:0]        w_mem_idx;
    logic [CW-1:0]     w_free;
    logic              w_push_reg, w_push_mem, w_pop;
    logic [1:0]        w_drop;
    logic [AW-1:0]     w_mem_ptr;
    logic [16:0]       w_ovf_sum;

    assign w_reg_ev = reg_write_sig && (reg_num != 5'd0);

`ifdef TRACE_MEM_EN
    // A simultaneous wr/rd is recorded as a single store; the load is ignored.
    assign w_mem_ev   = wr || rd;
    assign w_mem_kind = wr ? 2'b01 : 2'b10;
    assign w_mem_data = wr ? wr_data : rd_data;
    assign w_mem_idx  = addr;
`else
    logic w_unused_mem;
    assign w_unused_mem = ^{wr, rd, addr, wr_data, rd_data};
    assign w_mem_ev     = 1'b0;
    assign w_mem_kind   = 2'b00;
    assign w_mem_data   = '0;
    assign w_mem_idx    = '0;
`endif

    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    assign w_free     = DEPTH_C - r_count;
    assign w_push_reg = w_reg_ev && (w_free != '0);
    assign w_push_mem = w_mem_ev && (w_free >= (w_reg_ev ? CW'(2) : CW'(1)));
    assign w_pop      = (r_count != '0) && out_ready;
    assign w_drop     = 2'(w_reg_ev && !w_push_reg) + 2'(w_mem_ev && !w_push_mem);
    assign w_mem_ptr  = w_push_reg ? r_wr_ptr + AW'(1) : r_wr_ptr;
    assign w_ovf_sum  = {1'b0, r_ovf} + 17'(w_drop);

    always_ff @(posedge clk) begin
        if (w_push_reg) begin
            r_kind[r_wr_ptr] <= 2'b00;
            r_idx[r_wr_ptr]  <= {4'b0000, reg_num};
            r_data[r_wr_ptr] <= reg_data;
        end
        if (w_push_mem) begin
            r_kind[w_mem_ptr] <= w_mem_kind;
            r_idx[w_mem_ptr]  <= w_mem_idx;
            r_data[w_mem_ptr] <= w_mem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push_reg) + AW'(w_push_mem);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push_reg) + CW'(w_push_mem) - CW'(w_pop);
            r_ovf    <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_kind     = r_kind[r_rd_ptr];
    assign out_idx      = r_idx[r_rd_ptr];
    assign out_data     = r_data[r_rd_ptr];
    assign count        = r_count;
    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == '0);
    assign overflow_cnt = r_ovf;
endmodule
